// File: rtl/div_if.sv
// div_if: divider request/result bundle between the execute stage and div_iter.
interface div_if #(parameter int WIDTH = 32);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider, result_o = {remainder, quotient}.
// Optional macro DIV_SHORTCUT_EN adds a one-cycle FAST path when |a| < |b|.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic rst,
    div_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DZ, ON, END
`ifdef DIV_SHORTCUT_EN
        , FAST
`endif
    } state_t;
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q, quo_q, div_q, dvd_q;
    logic               sign_q_q, sign_r_q, ready_q;
    logic [2*WIDTH-1:0] result_q;
    logic               neg_a, neg_b, ge;
    logic [WIDTH-1:0]   abs_a, abs_b, diff, quo_f, rem_f;
    logic [WIDTH:0]     part;
    always_comb begin
        neg_a = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        neg_b = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        abs_a = neg_a ? -bus.opdata1_i : bus.opdata1_i;
        abs_b = neg_b ? -bus.opdata2_i : bus.opdata2_i;
        part  = {rem_q, quo_q[WIDTH-1]};
        ge    = part >= {1'b0, div_q};
        // part < 2*div whenever ge, so the difference always fits in WIDTH bits
        diff  = part[WIDTH-1:0] - div_q;
        quo_f = sign_q_q ? -quo_q : quo_q;
        rem_f = sign_r_q ? -rem_q : rem_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            dvd_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (state_q != IDLE && bus.annul_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i && !bus.annul_i) begin
                    dvd_q <= bus.opdata1_i;
                    if (bus.opdata2_i == '0)
                        state_q <= DZ;
`ifdef DIV_SHORTCUT_EN
                    else if (abs_a < abs_b)
                        state_q <= FAST;
`endif
                    else begin
                        state_q  <= ON;
                        cnt_q    <= '0;
                        rem_q    <= '0;
                        quo_q    <= abs_a;
                        div_q    <= abs_b;
                        sign_q_q <= neg_a ^ neg_b;
                        sign_r_q <= neg_a;
                    end
                end
                DZ: begin
                    state_q  <= END;
                    result_q <= {dvd_q, {WIDTH{1'b1}}};
                    ready_q  <= 1'b1;
                end
`ifdef DIV_SHORTCUT_EN
                FAST: begin
                    state_q  <= END;
                    result_q <= {dvd_q, {WIDTH{1'b0}}};
                    ready_q  <= 1'b1;
                end
`endif
                ON: if (cnt_q == CNT_W'(WIDTH)) begin
                    state_q  <= END;
                    result_q <= {rem_f, quo_f};
                    ready_q  <= 1'b1;
                end else begin
                    rem_q <= ge ? diff : part[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                end
                END: if (!bus.start_i) begin
                    state_q  <= IDLE;
                    result_q <= '0;
                    ready_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
`ifdef DIV_SHORTCUT_EN
    assign bus.busy_o = (state_q == ON) || (state_q == DZ) || (state_q == FAST);
`else
    assign bus.busy_o = (state_q == ON) || (state_q == DZ);
`endif
endmodule
